// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the canonical NOP encoding and
// the default reset vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/pc_inc.sv
// Program-counter incrementer: next sequential instruction address,
// wrapping modulo 2^WIDTH.
module pc_inc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + WIDTH'(4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request to instruction memory,
// registered hand-off to decode, branch/jump redirect with stale-response kill.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          PC_WIDTH    = 16,
    parameter int          INSTR_WIDTH = 32,
    parameter int unsigned RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   id_stall,
    output logic                   id_valid,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic [PC_WIDTH-1:0]    id_pc_plus4
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] fetch_pc_plus4;
    logic [PC_WIDTH-1:0] redirect_pc_aligned;
    logic                kill;
    logic                transfer;
    logic                fire;

    // Handshake: decode takes id_* at an edge with id_valid=1 and id_stall=0;
    // no new request is issued while a held instruction is stalled.
    assign transfer            = id_valid && !id_stall;
    assign imem_req            = (state == FETCH) && !(id_valid && id_stall);
    assign imem_addr           = pc;
    assign fire                = imem_req && imem_gnt;
    assign redirect_pc_aligned = redirect_pc & ~PC_WIDTH'(3);

    pc_inc #(.WIDTH(PC_WIDTH)) u_pc_inc (
        .pc       (fetch_pc),
        .pc_plus4 (fetch_pc_plus4)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= START;
            pc          <= RESET_PC_V;
            fetch_pc    <= '0;
            kill        <= 1'b0;
            id_valid    <= 1'b0;
            id_instr    <= INSTR_WIDTH'(NOP_INSTR);
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else begin
            if (transfer) id_valid <= 1'b0;

            case (state)
                START: state <= FETCH;
                FETCH: begin
                    if (fire) begin
                        fetch_pc <= pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                        kill  <= 1'b0;
                        if (!kill && !redirect) begin
                            id_instr    <= imem_rdata;
                            id_pc       <= fetch_pc;
                            id_pc_plus4 <= fetch_pc_plus4;
                            id_valid    <= 1'b1;
                            pc          <= fetch_pc_plus4;
                        end
                    end
                end
                default: state <= START;
            endcase

            // Redirect wins; a response already in flight is marked stale.
            if (redirect && state != START) begin
                pc       <= redirect_pc_aligned;
                id_valid <= 1'b0;
                if (state == WAIT)
                    kill <= !imem_rvalid;
                else if (fire)
                    kill <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table on a RESET_PC=0 instance,
// hand sequence for address wrap and mid-WAIT reset on a RESET_PC=0xFFFC one.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int PW = 16;
  localparam int IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  // instance a: RESET_PC = 0
  logic a_rst, a_gnt, a_rvalid, a_redirect, a_stall;
  logic [IW-1:0] a_rdata;
  logic [PW-1:0] a_redirect_pc;
  logic a_req, a_id_valid;
  logic [PW-1:0] a_addr, a_id_pc, a_id_pc4;
  logic [IW-1:0] a_id_instr;

  // instance b: RESET_PC = 0xFFFC
  logic b_rst, b_gnt, b_rvalid, b_redirect, b_stall;
  logic [IW-1:0] b_rdata;
  logic [PW-1:0] b_redirect_pc;
  logic b_req, b_id_valid;
  logic [PW-1:0] b_addr, b_id_pc, b_id_pc4;
  logic [IW-1:0] b_id_instr;

  fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(0)) dut_a (
    .clk(clk), .rst(a_rst),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(a_gnt),
    .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
    .redirect(a_redirect), .redirect_pc(a_redirect_pc), .id_stall(a_stall),
    .id_valid(a_id_valid), .id_instr(a_id_instr), .id_pc(a_id_pc), .id_pc_plus4(a_id_pc4)
  );

  fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'hFFFC)) dut_b (
    .clk(clk), .rst(b_rst),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc), .id_stall(b_stall),
    .id_valid(b_id_valid), .id_instr(b_id_instr), .id_pc(b_id_pc), .id_pc_plus4(b_id_pc4)
  );

  typedef struct {
    logic          gnt;
    logic          rvalid;
    logic [IW-1:0] rdata;
    logic          redirect;
    logic [PW-1:0] rpc;
    logic          stall;
    logic          e_req;
    logic [PW-1:0] e_addr;
    logic          e_idv;
    logic [PW-1:0] e_pc;
    logic [PW-1:0] e_pc4;
    logic [IW-1:0] e_instr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic g, input logic rv, input logic [IW-1:0] rd,
                              input logic rdr, input logic [PW-1:0] rpc, input logic st,
                              input logic ereq, input logic [PW-1:0] eaddr, input logic eidv,
                              input logic [PW-1:0] epc, input logic [PW-1:0] epc4,
                              input logic [IW-1:0] einstr);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redirect = rdr; v.rpc = rpc; v.stall = st;
    v.e_req = ereq; v.e_addr = eaddr; v.e_idv = eidv; v.e_pc = epc; v.e_pc4 = epc4;
    v.e_instr = einstr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic ereq, input logic [PW-1:0] eaddr,
                       input logic eidv, input logic [PW-1:0] epc, input logic [PW-1:0] epc4,
                       input logic [IW-1:0] einstr);
    chk({tag, " imem_req"},    32'(b_req),      32'(ereq));
    chk({tag, " imem_addr"},   32'(b_addr),     32'(eaddr));
    chk({tag, " id_valid"},    32'(b_id_valid), 32'(eidv));
    chk({tag, " id_pc"},       32'(b_id_pc),    32'(epc));
    chk({tag, " id_pc_plus4"}, 32'(b_id_pc4),   32'(epc4));
    chk({tag, " id_instr"},    b_id_instr,      einstr);
  endtask

  localparam logic [IW-1:0] I_A = 32'h0050_0093;
  localparam logic [IW-1:0] I_B = 32'h0010_0113;
  localparam logic [IW-1:0] I_C = 32'h2222_2222;
  localparam logic [IW-1:0] I_D = 32'h4444_4444;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  initial begin
    a_rst = 1'b0; a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
    a_redirect = 1'b0; a_redirect_pc = '0; a_stall = 1'b0;
    b_rst = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
    b_redirect = 1'b0; b_redirect_pc = '0; b_stall = 1'b0;

    //       gnt rv rdata          rdr rpc       st  req addr      idv pc        pc4       instr
    vecs[0]  = mk(0, 0, '0,            1, 16'h0080, 0,  0, 16'h0000, 0, 16'h0000, 16'h0000, NOP);
    vecs[1]  = mk(1, 0, '0,            0, 16'h0000, 0,  1, 16'h0000, 0, 16'h0000, 16'h0000, NOP);
    vecs[2]  = mk(0, 1, I_A,           0, 16'h0000, 0,  0, 16'h0000, 0, 16'h0000, 16'h0000, NOP);
    for (int i = 3; i <= 7; i++)
      vecs[i] = mk(1, 0, '0,           0, 16'h0000, 1,  0, 16'h0004, 1, 16'h0000, 16'h0004, I_A);
    vecs[8]  = mk(1, 0, '0,            0, 16'h0000, 0,  1, 16'h0004, 1, 16'h0000, 16'h0004, I_A);
    vecs[9]  = mk(0, 0, '0,            1, 16'h0042, 0,  0, 16'h0004, 0, 16'h0000, 16'h0004, I_A);
    vecs[10] = mk(0, 1, 32'hDEADBEEF,  0, 16'h0000, 0,  0, 16'h0040, 0, 16'h0000, 16'h0004, I_A);
    vecs[11] = mk(1, 0, '0,            0, 16'h0000, 0,  1, 16'h0040, 0, 16'h0000, 16'h0004, I_A);
    vecs[12] = mk(0, 1, I_B,           0, 16'h0000, 0,  0, 16'h0040, 0, 16'h0000, 16'h0004, I_A);
    vecs[13] = mk(0, 0, '0,            0, 16'h0000, 0,  1, 16'h0044, 1, 16'h0040, 16'h0044, I_B);
    vecs[14] = mk(0, 0, '0,            1, 16'h0010, 0,  1, 16'h0044, 0, 16'h0040, 16'h0044, I_B);
    vecs[15] = mk(1, 0, '0,            1, 16'h0100, 0,  1, 16'h0010, 0, 16'h0040, 16'h0044, I_B);
    vecs[16] = mk(0, 1, 32'h11111111,  0, 16'h0000, 0,  0, 16'h0100, 0, 16'h0040, 16'h0044, I_B);
    vecs[17] = mk(1, 0, '0,            0, 16'h0000, 0,  1, 16'h0100, 0, 16'h0040, 16'h0044, I_B);
    vecs[18] = mk(0, 0, '0,            0, 16'h0000, 0,  0, 16'h0100, 0, 16'h0040, 16'h0044, I_B);
    vecs[19] = mk(0, 0, '0,            0, 16'h0000, 0,  0, 16'h0100, 0, 16'h0040, 16'h0044, I_B);
    vecs[20] = mk(0, 1, I_C,           0, 16'h0000, 0,  0, 16'h0100, 0, 16'h0040, 16'h0044, I_B);
    vecs[21] = mk(1, 1, 32'h55555555,  0, 16'h0000, 0,  1, 16'h0104, 1, 16'h0100, 16'h0104, I_C);
    vecs[22] = mk(0, 1, 32'h33333333,  1, 16'h0203, 0,  0, 16'h0104, 0, 16'h0100, 16'h0104, I_C);
    vecs[23] = mk(1, 0, '0,            0, 16'h0000, 0,  1, 16'h0200, 0, 16'h0100, 16'h0104, I_C);
    vecs[24] = mk(0, 1, I_D,           0, 16'h0000, 0,  0, 16'h0200, 0, 16'h0100, 16'h0104, I_C);
    vecs[25] = mk(0, 0, '0,            1, 16'h0300, 1,  0, 16'h0204, 1, 16'h0200, 16'h0204, I_D);
    vecs[26] = mk(0, 0, '0,            0, 16'h0000, 0,  1, 16'h0300, 0, 16'h0200, 16'h0204, I_D);

    // instructions decode should accept, in order
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0100);

    // reset state of instance a
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset imem_req",    32'(a_req),      32'd0);
    chk("reset imem_addr",   32'(a_addr),     32'd0);
    chk("reset id_valid",    32'(a_id_valid), 32'd0);
    chk("reset id_instr",    a_id_instr,      NOP);
    chk("reset id_pc",       32'(a_id_pc),    32'd0);
    chk("reset id_pc_plus4", 32'(a_id_pc4),   32'd0);
    a_rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      a_gnt = vecs[i].gnt; a_rvalid = vecs[i].rvalid; a_rdata = vecs[i].rdata;
      a_redirect = vecs[i].redirect; a_redirect_pc = vecs[i].rpc; a_stall = vecs[i].stall;
      #1;
      chk($sformatf("row%0d imem_req", i),    32'(a_req),      32'(vecs[i].e_req));
      chk($sformatf("row%0d imem_addr", i),   32'(a_addr),     32'(vecs[i].e_addr));
      chk($sformatf("row%0d id_valid", i),    32'(a_id_valid), 32'(vecs[i].e_idv));
      chk($sformatf("row%0d id_pc", i),       32'(a_id_pc),    32'(vecs[i].e_pc));
      chk($sformatf("row%0d id_pc_plus4", i), 32'(a_id_pc4),   32'(vecs[i].e_pc4));
      chk($sformatf("row%0d id_instr", i),    a_id_instr,      vecs[i].e_instr);
      if (a_id_valid && !a_stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL row%0d transfer: got id_pc 0x%04h expected no transfer", i, a_id_pc);
        end else begin
          chk($sformatf("row%0d transfer id_pc", i), 32'(a_id_pc), 32'(exp_q.pop_front()));
        end
      end
      @(negedge clk);
    end
    chk("scoreboard leftover", 32'(exp_q.size()), 32'd0);
    a_gnt = 1'b0; a_rvalid = 1'b0; a_redirect = 1'b0;

    // instance b: wrap from 0xFFFC, then reset while a request is outstanding
    chk_b("b reset", 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    b_rst = 1'b1;
    #1 chk_b("b start", 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk); b_gnt = 1'b1;
    #1 chk_b("b fetch0", 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk); b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = I_A;
    #1 chk_b("b wait0", 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk); b_rvalid = 1'b0; b_gnt = 1'b1;
    #1 chk_b("b deliver0", 1'b1, 16'h0000, 1'b1, 16'hFFFC, 16'h0000, I_A);
    @(negedge clk); b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = I_B;
    #1 chk_b("b wait1", 1'b0, 16'h0000, 1'b0, 16'hFFFC, 16'h0000, I_A);
    @(negedge clk); b_rvalid = 1'b0; b_gnt = 1'b1;
    #1 chk_b("b deliver1", 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0004, I_B);
    @(negedge clk); b_gnt = 1'b0;
    #1 chk_b("b wait2", 1'b0, 16'h0004, 1'b0, 16'h0000, 16'h0004, I_B);
    #1 b_rst = 1'b0;
    #1 chk_b("b midwait reset", 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk); b_rst = 1'b1; b_rvalid = 1'b1; b_rdata = 32'h99999999;
    #1 chk_b("b late rvalid start", 1'b0, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk);
    #1 chk_b("b late rvalid fetch", 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);
    @(negedge clk); b_rvalid = 1'b0;
    #1 chk_b("b restart", 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, NOP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
